io_responder: RTL

- Device-side target for the I/O bus driven by the I/O bridge master port (cyc/stb/we/sel/adr/dat in, ack/dat out).
- Decodes its address window and holds a bank of byte-writable 32-bit registers plus a read-only ID register.
- Inserts programmable read/write wait states, then holds ack until the bridge drops strobe.
- Serves as the standard register front-end for low-speed peripherals hung off the bridge.

---
 rtl/io_responder_pkg.sv | 16 +
 rtl/io_bytewr_reg.sv | 26 ++
 rtl/io_responder.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/io_responder_pkg.sv
// Shared types and helpers for the io_responder register target.
package io_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_e;

  typedef logic [31:0] word_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/io_bytewr_reg.sv
// 32-bit register with per-byte write enables and synchronous reset.
module io_bytewr_reg
  import io_responder_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] d_i,
  output logic [31:0] q_o
);

  word_t q_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q <= '0;
    end else begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be_i[b]) q_q[b*8 +: 8] <= d_i[b*8 +: 8];
      end
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/io_responder.sv
// I/O bus register target: address decode, byte-writable register bank,
// read-only ID word, programmable wait states and strobe-held acknowledge.
module io_responder
  import io_responder_pkg::*;
#(
  parameter int unsigned WID   = 32,
  parameter logic [31:0] BASE  = 32'hFD0C_0000,
  parameter logic [31:0] MASK  = 32'hFFFF_0000,
  parameter int unsigned NREG  = 16,
  parameter int unsigned WAITS = 1,
  parameter logic [31:0] ID    = 32'h494F_5230
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cyc_i,
  input  logic                 stb_i,
  input  logic                 we_i,
  input  logic [3:0]           sel_i,
  input  logic [31:0]          adr_i,
  input  logic [WID-1:0]       dat_i,
  output logic                 ack_o,
  output logic [WID-1:0]       dat_o,
  output logic [NREG*32-1:0]   regs_o,
  output logic                 wr_stb_o,
  output logic [5:0]           wr_idx_o
);

  localparam int unsigned IW = idx_width(NREG);

  state_e        state_q;
  logic [3:0]    cnt_q;
  logic          we_q;
  logic [3:0]    sel_q;
  word_t         dat_q;
  logic [IW-1:0] idx_q;
  logic          mapped_q;
  logic          ack_q;
  word_t         rdat_q;
  logic          wr_stb_q;
  logic [5:0]    wr_idx_q;

  logic [31:0]   off;
  logic          hit;
  logic          mapped;
  logic [IW-1:0] idx;

  logic          t_we;
  logic [3:0]    t_sel;
  word_t         t_dat;
  logic [IW-1:0] t_idx;
  logic          t_mapped;
  logic          enter_ack;
  logic          do_wr;

  word_t         rv [NREG];

  assign off    = adr_i & ~MASK;
  assign hit    = cyc_i & stb_i & ((adr_i & MASK) == BASE);
  assign mapped = off < 32'(NREG * 4);
  assign idx    = off[IW+1:2];

  // With zero wait states ACK is entered straight from IDLE, so the request
  // fields must come from the bus rather than from the capture registers.
  always_comb begin
    if (state_q == IDLE) begin
      t_we     = we_i;
      t_sel    = sel_i;
      t_dat    = dat_i;
      t_idx    = idx;
      t_mapped = mapped;
    end else begin
      t_we     = we_q;
      t_sel    = sel_q;
      t_dat    = dat_q;
      t_idx    = idx_q;
      t_mapped = mapped_q;
    end
  end

  always_comb begin
    enter_ack = 1'b0;
    if (state_q == IDLE && hit && WAITS == 0) enter_ack = 1'b1;
    if (state_q == WAIT && cyc_i && cnt_q == 4'd1) enter_ack = 1'b1;
  end

  assign do_wr = enter_ack && t_we && t_mapped && (t_idx != IW'(NREG - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      sel_q    <= '0;
      dat_q    <= '0;
      idx_q    <= '0;
      mapped_q <= 1'b0;
      ack_q    <= 1'b0;
      rdat_q   <= '0;
      wr_stb_q <= 1'b0;
      wr_idx_q <= '0;
    end else begin
      wr_stb_q <= 1'b0;
      if (enter_ack) begin
        ack_q    <= 1'b1;
        wr_stb_q <= do_wr;
        if (do_wr) wr_idx_q <= 6'(t_idx);
        rdat_q   <= (!t_we && t_mapped) ? rv[t_idx] : '0;
      end
      unique case (state_q)
        IDLE: begin
          if (hit) begin
            we_q     <= we_i;
            sel_q    <= sel_i;
            dat_q    <= dat_i;
            idx_q    <= idx;
            mapped_q <= mapped;
            cnt_q    <= 4'(WAITS);
            state_q  <= (WAITS == 0) ? ACK : WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (!cyc_i)              state_q <= IDLE;
          else if (cnt_q == 4'd1)  state_q <= ACK;
        end
        ACK: begin
          if (!stb_i || !cyc_i) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            rdat_q  <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NREG - 1; g++) begin : g_reg
    io_bytewr_reg u_reg (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .be_i  ((do_wr && t_idx == IW'(g)) ? t_sel : 4'b0000),
      .d_i   (t_dat),
      .q_o   (rv[g])
    );
  end

  assign rv[NREG-1] = ID;

  for (genvar g = 0; g < NREG; g++) begin : g_flat
    assign regs_o[g*32 +: 32] = rv[g];
  end

  assign ack_o    = ack_q;
  assign dat_o    = rdat_q;
  assign wr_stb_o = wr_stb_q;
  assign wr_idx_o = wr_idx_q;

endmodule
